// File: rtl/mimo_precoder.sv
// mimo_precoder: y = H*x for a 4x4 complex Q2.13 channel matrix, one time-shared complex MAC.
// Build option: define PRECODER_ROUND_EN to round half up before rescaling (default truncates).
module mimo_precoder #(
    parameter int FRAC_BITS = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             h_wr_en,
    input  logic [3:0]       h_wr_addr,
    input  logic [15:0]      h_wr_real,
    input  logic [15:0]      h_wr_imag,
    output logic             h_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0][15:0] x_real,
    input  logic [3:0][15:0] x_imag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0][15:0] y_real,
    output logic [3:0][15:0] y_imag
);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        HOLD
    } state_t;

    state_t state;

    logic signed [15:0] h_re [16];
    logic signed [15:0] h_im [16];
    logic signed [15:0] x_re_q [4];
    logic signed [15:0] x_im_q [4];

    // cnt walks row-major over H, so it doubles as the H index; cnt[1:0] selects x[k].
    logic [3:0]         cnt;
    logic signed [33:0] acc_re;
    logic signed [33:0] acc_im;

    logic signed [15:0] ar, ai, br, bi;
    logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [33:0] prod_re, prod_im;
    logic signed [33:0] acc_re_nxt, acc_im_nxt;
    logic [15:0]        y_re_nxt, y_im_nxt;

    // Rescale a Q4.26 accumulator to Q2.13 and clamp to the 16-bit signed range.
    function automatic logic [15:0] scale_sat(input logic signed [33:0] acc);
        logic signed [34:0] biased;
        logic signed [34:0] shifted;
        biased = 35'(acc);
`ifdef PRECODER_ROUND_EN
        biased = biased + (35'sd1 <<< (FRAC_BITS - 1));
`endif
        shifted = biased >>> FRAC_BITS;
        if (shifted > 35'sd32767) begin
            return 16'h7FFF;
        end else if (shifted < -35'sd32768) begin
            return 16'h8000;
        end else begin
            return shifted[15:0];
        end
    endfunction

    // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
    always_comb begin
        ar         = h_re[cnt];
        ai         = h_im[cnt];
        br         = x_re_q[cnt[1:0]];
        bi         = x_im_q[cnt[1:0]];
        p_rr       = 32'(ar) * 32'(br);
        p_ii       = 32'(ai) * 32'(bi);
        p_ri       = 32'(ar) * 32'(bi);
        p_ir       = 32'(ai) * 32'(br);
        prod_re    = 34'(p_rr) - 34'(p_ii);
        prod_im    = 34'(p_ri) + 34'(p_ir);
        acc_re_nxt = acc_re + prod_re;
        acc_im_nxt = acc_im + prod_im;
        y_re_nxt   = scale_sat(acc_re_nxt);
        y_im_nxt   = scale_sat(acc_im_nxt);
    end

    // NOTE: the coefficient array is reset because H must read as zero after reset;
    // a storage array without that requirement would be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                h_re[i] <= '0;
                h_im[i] <= '0;
            end
        end else if (h_wr_en && state == IDLE) begin
            h_re[h_wr_addr] <= h_wr_real;
            h_im[h_wr_addr] <= h_wr_imag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            h_err     <= 1'b0;
            cnt       <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            y_real    <= '0;
            y_imag    <= '0;
            for (int k = 0; k < 4; k++) begin
                x_re_q[k] <= '0;
                x_im_q[k] <= '0;
            end
        end else begin
            h_err <= h_wr_en && (state != IDLE);
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int k = 0; k < 4; k++) begin
                            x_re_q[k] <= x_real[k];
                            x_im_q[k] <= x_imag[k];
                        end
                        cnt      <= '0;
                        acc_re   <= '0;
                        acc_im   <= '0;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                MAC: begin
                    cnt <= cnt + 4'd1;
                    // Last column of a row: retire y[i] and clear for the next row.
                    if (cnt[1:0] == 2'd3) begin
                        y_real[cnt[3:2]] <= y_re_nxt;
                        y_imag[cnt[3:2]] <= y_im_nxt;
                        acc_re           <= '0;
                        acc_im           <= '0;
                    end else begin
                        acc_re <= acc_re_nxt;
                        acc_im <= acc_im_nxt;
                    end
                    if (cnt == 4'd15) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
